elevator_car_fsm: RTL and testbench
===================================

ELEVATOR_CAR_FSM -- requirements
Module: elevator_car_fsm

Interface
REQ-001 Parameter FLOOR_TICKS, default 16, clock cycles of travel per floor; legal range 1..65535.
REQ-002 Parameter DOOR_TICKS, default 8, clock cycles the door stays open; legal range 1..65535.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-low reset; reset low at a rising clk edge resets the block.
REQ-005 call_req  input  4  floor call buttons; bit n high on any edge registers a call for floor n.
REQ-006 floor  output  2  current car floor, 0..3.
REQ-007 UES  output  1  upper end stop; high exactly when floor==3.
REQ-008 LES  output  1  lower end stop; high exactly when floor==0.
REQ-009 IS  output  1  in-motion status; high exactly in states MOVE_UP and MOVE_DOWN.
REQ-010 door_open  output  1  high exactly in state DOOR_OPEN.
REQ-011 dir_up  output  1  travel direction register; 1 = up, 0 = down.
REQ-012 pending  output  4  registered outstanding calls, one bit per floor.

Function
REQ-013 All outputs SHALL be registered or decoded only from registers; no combinational path from call_req to any output.
REQ-014 States SHALL be IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN.
REQ-015 call_req bit n SHALL set pending[n] on the next edge and hold it until served; repeated presses have no further effect.
REQ-016 Exception: call_req[floor] while in IDLE or DOOR_OPEN SHALL not set pending; it SHALL enter/restart DOOR_OPEN (door counter reloaded to zero).
REQ-017 "Above" = pending bits for floors > floor; "below" = bits for floors < floor.
REQ-018 Direction choice (IDLE or end of DOOR_OPEN): if pending in dir_up direction, move that way; else if pending in opposite direction, flip dir_up and move; else IDLE.
REQ-019 IDLE -> MOVE_* or DOOR_OPEN SHALL occur on the edge after the triggering pending bit/call_req is visible (one-cycle latency).
REQ-020 MOVE_*: 16-bit travel counter starts at 0 on entry, increments each cycle; on the edge where it equals FLOOR_TICKS-1, floor increments (MOVE_UP) or decrements (MOVE_DOWN) and counter clears.
REQ-021 On arrival at floor f: if pending[f] (including a bit set that same cycle), clear pending[f] and enter DOOR_OPEN; else continue in the same state.
REQ-022 floor SHALL never wrap: MOVE_UP is never entered or continued at floor 3, MOVE_DOWN never at floor 0.
REQ-023 DOOR_OPEN SHALL last exactly DOOR_TICKS cycles (absent REQ-016 restarts), then apply REQ-018.
REQ-024 A call set and cleared in the same cycle (arrival at that floor) SHALL leave pending[f]=0.
REQ-025 Simultaneous calls above and below while IDLE SHALL follow dir_up per REQ-018.

Reset
REQ-026 reset low at an edge SHALL force: state IDLE, floor=0, dir_up=1, pending=0, counters=0, hence UES=0, LES=1, IS=0, door_open=0.
REQ-027 reset SHALL override all activity, including mid-move and mid-door; call_req during reset is discarded.
REQ-028 Block SHALL resume normal operation on the first edge with reset high.

Verification (FLOOR_TICKS=4, DOOR_TICKS=3)
REQ-029 Reset low 2 cycles -> floor=0, LES=1, UES=0, IS=0, door_open=0, dir_up=1, pending=0000.
REQ-030 Idle at 0, one-cycle call_req=0100 -> pending=0100 next edge, IS=1 the edge after, floor=1 4 cycles later, floor=2 4 more, then door_open=1 for 3 cycles, pending=0000, then IDLE.
REQ-031 Idle at 0, call_req=0001 -> door_open=1 next edge for 3 cycles, IS never 1; press again during door -> door time restarts.
REQ-032 Moving up 0->3 (call 1000), press 0100 before floor reaches 2 -> stops at 2 (door 3 cycles), continues to 3, UES=1.
REQ-033 At floor 1 moving up to 3, press 0001 -> serves 3 first, dir_up flips to 0, travels down, LES=1 at arrival, pending=0000.
REQ-034 reset low while IS=1 at floor 2 -> next edge floor=0, IS=0, pending=0000, dir_up=1.

Source files
------------

// File: rtl/elevator_car_fsm_if.sv
// Car interface: the floor call buttons going in, and the registered car status coming out.
interface elevator_car_fsm_if;
    logic [3:0] call_req;
    logic [1:0] floor;
    logic       UES;
    logic       LES;
    logic       IS;
    logic       door_open;
    logic       dir_up;
    logic [3:0] pending;

    // The master presses the buttons and watches the status.
    modport master (
        output call_req,
        input  floor, UES, LES, IS, door_open, dir_up, pending
    );

    // The car controller takes the buttons and drives the status.
    modport slave (
        input  call_req,
        output floor, UES, LES, IS, door_open, dir_up, pending
    );
endinterface

// File: rtl/elevator_car_fsm.sv
// Four-floor elevator car controller.
// Calls are latched into a pending mask. The car keeps its current direction
// while there are calls ahead of it, and flips direction only when no calls
// remain ahead. Every status output comes straight from a register, or from a
// decode of registers.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | parked with the door closed; waiting for a call
// MOVE_UP   | travelling up; the travel counter times each floor
// MOVE_DOWN | travelling down; the travel counter times each floor
// DOOR_OPEN | door open at the current floor for DOOR_TICKS cycles
module elevator_car_fsm #(
    parameter int unsigned FLOOR_TICKS = 16,
    parameter int unsigned DOOR_TICKS  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    elevator_car_fsm_if.slave    bus
);

    typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN} state_t;

    localparam logic [15:0] FLOOR_LAST = 16'(FLOOR_TICKS - 1);
    localparam logic [15:0] DOOR_LAST  = 16'(DOOR_TICKS - 1);

    state_t      state_q, state_d;
    logic [1:0]  floor_q, floor_d;
    logic        dir_up_q, dir_up_d;
    logic [3:0]  pending_q, pending_d;
    logic [15:0] cnt_q, cnt_d;

    logic [3:0]  here;
    logic [3:0]  above;
    logic [3:0]  below;
    logic [3:0]  calls_all;
    logic [1:0]  arr_floor;
    logic [3:0]  arr_hot;
    logic        go_up;
    logic        go_down;

    // Next-state logic: the direction choice, the travel and door timing, and the pending-call bookkeeping.
    always_comb begin
        state_d   = state_q;
        floor_d   = floor_q;
        dir_up_d  = dir_up_q;
        cnt_d     = cnt_q;
        calls_all = pending_q | bus.call_req;
        pending_d = calls_all;
        here      = 4'b0001 << floor_q;
        above     = pending_q & (4'b1110 << floor_q);
        below     = pending_q & ~(4'b1111 << floor_q);
        arr_floor = floor_q;
        arr_hot   = here;

        // Keep going the current way while calls remain ahead; otherwise turn round.
        if (dir_up_q) begin
            go_up   = |above;
            go_down = ~(|above) & (|below);
        end else begin
            go_down = |below;
            go_up   = ~(|below) & (|above);
        end

        case (state_q)
            IDLE, DOOR_OPEN: begin
                // A call for the floor the car is standing at opens the door.
                // It never becomes a pending call.
                pending_d = pending_q | (bus.call_req & ~here);
                if (|(bus.call_req & here)) begin
                    state_d = DOOR_OPEN;
                    cnt_d   = 16'd0;
                end else if (state_q == DOOR_OPEN && cnt_q != DOOR_LAST) begin
                    cnt_d = cnt_q + 16'd1;
                end else begin
                    cnt_d = 16'd0;
                    if (go_up) begin
                        state_d  = MOVE_UP;
                        dir_up_d = 1'b1;
                    end else if (go_down) begin
                        state_d  = MOVE_DOWN;
                        dir_up_d = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            MOVE_UP, MOVE_DOWN: begin
                if (cnt_q == FLOOR_LAST) begin
                    arr_floor = (state_q == MOVE_UP) ? floor_q + 2'd1 : floor_q - 2'd1;
                    arr_hot   = 4'b0001 << arr_floor;
                    floor_d   = arr_floor;
                    cnt_d     = 16'd0;
                    if (|(calls_all & arr_hot)) begin
                        // A call for this floor that arrives on the same edge is served now, so it is never latched.
                        pending_d = calls_all & ~arr_hot;
                        state_d   = DOOR_OPEN;
                    end else if ((state_q == MOVE_UP   && arr_floor == 2'd3) ||
                                 (state_q == MOVE_DOWN && arr_floor == 2'd0)) begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with a synchronous active-low reset; reset wins over any call or motion.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            floor_q   <= 2'd0;
            dir_up_q  <= 1'b1;
            pending_q <= 4'd0;
            cnt_q     <= 16'd0;
        end else begin
            state_q   <= state_d;
            floor_q   <= floor_d;
            dir_up_q  <= dir_up_d;
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.floor     = floor_q;
    assign bus.UES       = (floor_q == 2'd3);
    assign bus.LES       = (floor_q == 2'd0);
    assign bus.IS        = (state_q == MOVE_UP) || (state_q == MOVE_DOWN);
    assign bus.door_open = (state_q == DOOR_OPEN);
    assign bus.dir_up    = dir_up_q;
    assign bus.pending   = pending_q;

endmodule

// File: tb/tb_elevator_car_fsm.sv
// Directed bench for elevator_car_fsm with FLOOR_TICKS=4 and DOOR_TICKS=3.
module tb_elevator_car_fsm;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    elevator_car_fsm_if bus();

    elevator_car_fsm #(.FLOOR_TICKS(4), .DOOR_TICKS(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        bus.call_req = 4'b0000;

        // Reset held low for two edges.
        tick(2);
        check("rst_floor", 16'(bus.floor), 16'd0);
        check("rst_LES", 16'(bus.LES), 16'd1);
        check("rst_UES", 16'(bus.UES), 16'd0);
        check("rst_IS", 16'(bus.IS), 16'd0);
        check("rst_door", 16'(bus.door_open), 16'd0);
        check("rst_dir", 16'(bus.dir_up), 16'd1);
        check("rst_pend", 16'(bus.pending), 16'd0);
        reset = 1'b1;

        // A call for the car's own floor opens the door for 3 cycles, and a repeat press restarts the timer.
        bus.call_req = 4'b0001;
        tick(1);
        check("B_door_on", 16'(bus.door_open), 16'd1);
        check("B_pend", 16'(bus.pending), 16'd0);
        check("B_IS", 16'(bus.IS), 16'd0);
        bus.call_req = 4'b0000;
        tick(2);
        check("B_door_c3", 16'(bus.door_open), 16'd1);
        tick(1);
        check("B_door_off", 16'(bus.door_open), 16'd0);
        check("B_IS2", 16'(bus.IS), 16'd0);
        bus.call_req = 4'b0001;
        tick(1);
        bus.call_req = 4'b0000;
        tick(1);
        bus.call_req = 4'b0001;
        tick(1);
        bus.call_req = 4'b0000;
        tick(1);
        check("B_restart1", 16'(bus.door_open), 16'd1);
        tick(1);
        check("B_restart2", 16'(bus.door_open), 16'd1);
        tick(1);
        check("B_restart_end", 16'(bus.door_open), 16'd0);
        check("B_pend2", 16'(bus.pending), 16'd0);

        // Single call to floor 2 from floor 0.
        bus.call_req = 4'b0100;
        tick(1);
        check("A_pend", 16'(bus.pending), 16'h4);
        check("A_IS0", 16'(bus.IS), 16'd0);
        bus.call_req = 4'b0000;
        tick(1);
        check("A_IS1", 16'(bus.IS), 16'd1);
        tick(3);
        check("A_floor0", 16'(bus.floor), 16'd0);
        tick(1);
        check("A_floor1", 16'(bus.floor), 16'd1);
        tick(3);
        check("A_floor1b", 16'(bus.floor), 16'd1);
        tick(1);
        check("A_floor2", 16'(bus.floor), 16'd2);
        check("A_door", 16'(bus.door_open), 16'd1);
        check("A_IS_stop", 16'(bus.IS), 16'd0);
        check("A_pend0", 16'(bus.pending), 16'd0);
        tick(2);
        check("A_door3", 16'(bus.door_open), 16'd1);
        tick(1);
        check("A_door_off", 16'(bus.door_open), 16'd0);
        check("A_idle_IS", 16'(bus.IS), 16'd0);

        // Reset while moving up out of floor 2; a call made during reset is dropped.
        bus.call_req = 4'b1000;
        tick(1);
        bus.call_req = 4'b0000;
        tick(1);
        check("R_IS", 16'(bus.IS), 16'd1);
        check("R_floor2", 16'(bus.floor), 16'd2);
        tick(1);
        reset = 1'b0;
        bus.call_req = 4'b0010;
        tick(1);
        check("R_floor", 16'(bus.floor), 16'd0);
        check("R_IS0", 16'(bus.IS), 16'd0);
        check("R_pend", 16'(bus.pending), 16'd0);
        check("R_dir", 16'(bus.dir_up), 16'd1);
        check("R_LES", 16'(bus.LES), 16'd1);
        reset = 1'b1;
        bus.call_req = 4'b0000;
        tick(1);
        check("R_pend_after", 16'(bus.pending), 16'd0);
        check("R_IS_after", 16'(bus.IS), 16'd0);

        // Heading for floor 3, with a stop at floor 2 added on the way.
        bus.call_req = 4'b1000;
        tick(1);
        bus.call_req = 4'b0000;
        tick(5);
        check("C_floor1", 16'(bus.floor), 16'd1);
        check("C_IS", 16'(bus.IS), 16'd1);
        bus.call_req = 4'b0100;
        tick(1);
        check("C_pend", 16'(bus.pending), 16'hC);
        bus.call_req = 4'b0000;
        tick(3);
        check("C_floor2", 16'(bus.floor), 16'd2);
        check("C_door2", 16'(bus.door_open), 16'd1);
        check("C_pend2", 16'(bus.pending), 16'h8);
        tick(3);
        check("C_resume", 16'(bus.IS), 16'd1);
        check("C_door_off", 16'(bus.door_open), 16'd0);
        tick(4);
        check("C_floor3", 16'(bus.floor), 16'd3);
        check("C_UES", 16'(bus.UES), 16'd1);
        check("C_door3", 16'(bus.door_open), 16'd1);
        check("C_pend3", 16'(bus.pending), 16'd0);
        tick(3);
        check("C_idle", 16'(bus.door_open | bus.IS), 16'd0);

        // From floor 1 going up to 3, a call for floor 0: serve 3, then turn and come down.
        reset = 1'b0;
        tick(1);
        reset = 1'b1;
        bus.call_req = 4'b1000;
        tick(1);
        bus.call_req = 4'b0000;
        tick(5);
        check("D_floor1", 16'(bus.floor), 16'd1);
        bus.call_req = 4'b0001;
        tick(1);
        check("D_pend", 16'(bus.pending), 16'h9);
        bus.call_req = 4'b0000;
        tick(3);
        check("D_pass2", 16'(bus.IS), 16'd1);
        check("D_floor2", 16'(bus.floor), 16'd2);
        tick(4);
        check("D_floor3", 16'(bus.floor), 16'd3);
        check("D_door3", 16'(bus.door_open), 16'd1);
        check("D_pend3", 16'(bus.pending), 16'h1);
        tick(3);
        check("D_dir_flip", 16'(bus.dir_up), 16'd0);
        check("D_IS_down", 16'(bus.IS), 16'd1);
        tick(8);
        check("D_floor1b", 16'(bus.floor), 16'd1);
        tick(4);
        check("D_floor0", 16'(bus.floor), 16'd0);
        check("D_LES", 16'(bus.LES), 16'd1);
        check("D_door0", 16'(bus.door_open), 16'd1);
        check("D_pend0", 16'(bus.pending), 16'd0);
        tick(3);
        check("D_idle", 16'(bus.door_open | bus.IS), 16'd0);
        check("D_dir_end", 16'(bus.dir_up), 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
